ofmap_drain: RTL
================

// Module: ofmap_drain
// PURPOSE
//  Downstream of the PE accumulator stage. Captures one accumulated 5x5 output feature map (25 x 16-bit signed words) on a
//  frame-valid pulse. Requantizes each word to 8 bits with a rounding arithmetic shift and saturation.
//  Streams the words out one per beat, in raster order, on a valid/ready interface with row/col tags.
//  Frees the accumulator outputs so the next map can accumulate while this one drains.
// PARAMETERS
//  word_length        8   output element width (signed)
//  double_word_length 16  accumulated element width (signed)
//  output_col_size    5   columns per output map
//  output_size        25  elements per map (rows = output_size/output_col_size)
//  SHIFT              4   requant right-shift amount, 0..double_word_length-1
//  IDX_W              5   width of index/row/col tags, >= clog2(output_size)
// PORTS
//  clk        in   1                             clock
//  rst        in   1                             reset, asynchronous, active-high
//  in_valid   in   1                             pulse: data_in holds a complete accumulated map
//  data_in    in   output_size*double_word_length  word w at [w*16 +: 16], w = row*output_col_size+col
//  in_ready   out  1                             high when a map can be captured (IDLE)
//  out_valid  out  1                             data_out/tags valid
//  out_ready  in   1                             consumer accepts beat when out_valid&out_ready
//  data_out   out  word_length                   requantized element
//  out_row    out  IDX_W                         row of current element
//  out_col    out  IDX_W                         col of current element
//  out_last   out  1                             high with element output_size-1
//  overrun    out  1                             sticky: in_valid arrived while in_ready=0
// BEHAVIOUR
//  - Reset (async): state=IDLE, buffer=0, idx/row/col=0, in_ready=0 during rst then 1, out_valid=0, data_out=0, out_last=0, overrun=0.
//  - FSM IDLE: in_ready=1, out_valid=0. in_valid=1 -> register whole data_in into buffer, idx=row=col=0, go STREAM next cycle.
//  - FSM STREAM: in_ready=0, out_valid=1; data_out/out_row/out_col/out_last driven from registered buffer+counters only (no in->out comb path).
//  - Beat accepted (out_valid&out_ready): idx+1; col+1, col wraps to 0 at output_col_size-1 with row+1.
//  - Accept at idx=output_size-1 (out_last=1): go IDLE; counters reset to 0. Capture-to-first-valid latency = 1 cycle.
//  - out_ready low: hold data_out, tags, out_valid stable (no drop, no repeat). out_valid never deasserts mid-map.
//  - in_valid while in STREAM: map ignored, buffer untouched, overrun set (cleared only by rst).
//  - in_valid on the cycle of the final accept: still STREAM, so ignored + overrun; capture needs in_ready=1.
//  - Requant per element, 17-bit signed intermediate (no overflow):
//    t = x + (SHIFT>0 ? 1<<(SHIFT-1) : 0); y = t >>> SHIFT.
//    Saturate y to [-2^(word_length-1), 2^(word_length-1)-1].
//  - rst mid-stream: abandons the map immediately; no partial continuation after release.
// CONFIGURATION
//  OFMAP_DRAIN_RELU_EN defined: ReLU after requant; negative y -> 0, output range [0, 2^(word_length-1)-1].
//  OFMAP_DRAIN_RELU_EN undefined: signed saturated output as above. Handshake and timing identical in both builds.
// TESTING
//  1 Reset: assert rst mid-STREAM -> out_valid=0, in_ready=1 after release, overrun=0, data_out=0.
//  2 Requant: w0=0x0100, w1=0x7FFF, w2=0xFF00, w3=0x8000, SHIFT=4, out_ready=1.
//    -> data_out 0x10, 0x7F, 0xF0, 0x80 (RELU_EN: 0x10, 0x7F, 0x00, 0x00).
//  3 Order/tags: word w = w, out_ready=1 -> 25 beats on consecutive cycles; (row,col) (0,0)..(0,4),(1,0)..(4,4).
//    out_last only on beat 25; in_ready=1 the cycle after.
//  4 Backpressure: toggle out_ready 1,0,0,1 each cycle -> every element seen exactly once in order; outputs stable while stalled.
//  5 Overrun: pulse in_valid with new map at beat 10 -> overrun=1, remaining beats still from first map; next in_valid in IDLE captured.
//  6 Back-to-back: in_valid the cycle in_ready returns -> STREAM next cycle, overrun stays 0.

Source files
------------

// File: rtl/ofmap_drain.sv
// ofmap_drain: captures one accumulated output feature map (output_size signed words of
// double_word_length bits) on an in_valid pulse, requantizes each word to word_length bits with
// a rounding arithmetic right shift and saturation, and streams the words out in raster order.
// The output is a valid/ready interface that carries row/col tags and a last-beat flag.
//
// Build option: define OFMAP_DRAIN_RELU_EN to clamp negative requantized values to zero.
//
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset
//   in_valid  pulse: data_in holds a complete accumulated map
//   data_in   packed map, word w at [w*double_word_length +: double_word_length]
//   in_ready  high when a map can be captured (idle and not in reset)
//   out_valid data_out/out_row/out_col/out_last are valid
//   out_ready consumer accepts a beat when out_valid & out_ready
//   data_out  requantized element
//   out_row   row tag of the current element
//   out_col   column tag of the current element
//   out_last  high with the final element of the map
//   overrun   sticky: in_valid arrived while in_ready was low (cleared only by rst)
module ofmap_drain #(
  parameter int unsigned word_length        = 8,
  parameter int unsigned double_word_length = 16,
  parameter int unsigned output_col_size    = 5,
  parameter int unsigned output_size        = 25,
  parameter int unsigned SHIFT              = 4,
  parameter int unsigned IDX_W              = 5
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  input  logic [output_size*double_word_length-1:0]  data_in,
  output logic                                       in_ready,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [word_length-1:0]                     data_out,
  output logic [IDX_W-1:0]                           out_row,
  output logic [IDX_W-1:0]                           out_col,
  output logic                                       out_last,
  output logic                                       overrun
);

  // One extra bit so adding the rounding constant can never overflow.
  localparam int unsigned TW = double_word_length + 1;
  localparam logic signed [TW-1:0] Rnd    = TW'((32'd1 << SHIFT) >> 1);
  localparam logic signed [TW-1:0] SatMax = (TW'(1) << (word_length - 1)) - TW'(1);
  localparam logic signed [TW-1:0] SatMin = -(TW'(1) << (word_length - 1));

  typedef enum logic [0:0] {StIdle, StStream} state_t;

  state_t                        r_state, w_state_d;
  logic [double_word_length-1:0] r_buf [output_size];
  logic [IDX_W-1:0]              r_idx, r_row, r_col;
  logic                          r_overrun;

  logic                          w_in_ready, w_capture, w_accept, w_last;
  logic [double_word_length-1:0] w_word;
  logic signed [TW-1:0]          w_x, w_t, w_y;
  logic [word_length-1:0]        w_q;

  assign w_in_ready = (r_state == StIdle) && !rst;
  assign w_capture  = in_valid && w_in_ready;
  assign w_accept   = (r_state == StStream) && out_ready;
  assign w_last     = (r_idx == IDX_W'(output_size - 1));

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_capture) w_state_d = StStream;
      StStream: if (w_accept && w_last) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Requantize the buffered word selected by the beat counter; output depends on registers only.
  always_comb begin
    w_word = r_buf[r_idx];
    w_x    = $signed({w_word[double_word_length-1], w_word});
    w_t    = w_x + Rnd;
    w_y    = w_t >>> SHIFT;
    if (w_y > SatMax) begin
      w_q = {1'b0, {(word_length - 1){1'b1}}};
    end else if (w_y < SatMin) begin
      w_q = {1'b1, {(word_length - 1){1'b0}}};
    end else begin
      w_q = w_y[word_length-1:0];
    end
`ifdef OFMAP_DRAIN_RELU_EN
    if (w_y[TW-1]) w_q = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_idx     <= '0;
      r_row     <= '0;
      r_col     <= '0;
      r_overrun <= 1'b0;
      for (int i = 0; i < output_size; i++) r_buf[i] <= '0;
    end else begin
      r_state <= w_state_d;
      if (in_valid && !w_in_ready) r_overrun <= 1'b1;
      if (w_capture) begin
        for (int i = 0; i < output_size; i++) begin
          r_buf[i] <= data_in[i*double_word_length +: double_word_length];
        end
        r_idx <= '0;
        r_row <= '0;
        r_col <= '0;
      end else if (w_accept) begin
        if (w_last) begin
          r_idx <= '0;
          r_row <= '0;
          r_col <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
          if (r_col == IDX_W'(output_col_size - 1)) begin
            r_col <= '0;
            r_row <= r_row + IDX_W'(1);
          end else begin
            r_col <= r_col + IDX_W'(1);
          end
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == StStream);
  assign data_out  = out_valid ? w_q : '0;
  assign out_row   = r_row;
  assign out_col   = r_col;
  assign out_last  = out_valid && w_last;
  assign overrun   = r_overrun;

endmodule
